nf10_axis_pkt_checker: RTL and testbench

AXI4-Stream sink that consumes the test packet stream produced by the converter test traffic generator. It checks every byte of every packet against the fixed test-packet format. It also checks packet length (tlast position) and tuser, counts good and bad packets, and optionally throttles tready with a pseudo-random pattern. It sits at the master output of a converter chain as the self-checking receive end in simulation and on-board loopback tests.

---
 rtl/nf10_axis_checker_pkg.sv | 19 +
 rtl/nf10_axis_pkt_checker_if.sv | 14 +
 rtl/nf10_lfsr16.sv | 16 +
 rtl/nf10_axis_pkt_checker.sv | 96 +++++++++
 tb/tb_nf10_axis_pkt_checker.sv | 122 ++++++++++++
 5 files changed

// File: rtl/nf10_axis_checker_pkg.sv
// nf10_axis_checker_pkg: shared types and constants for the AXIS test-packet checker.
package nf10_axis_checker_pkg;
   typedef enum logic [1:0] {IDLE, PKT, DRAIN} state_t;
   localparam logic [2:0] ERR_NONE  = 3'd0;
   localparam logic [2:0] ERR_STRB  = 3'd1;
   localparam logic [2:0] ERR_TUSER = 3'd2;
   localparam logic [2:0] ERR_EARLY = 3'd3;
   localparam logic [2:0] ERR_OVER  = 3'd4;
   localparam logic [2:0] ERR_DATA  = 3'd5;
   localparam logic [63:0] HDR_WORD0 = 64'hEFBEFECAFECAFECA;
   localparam logic [63:0] HDR_WORD1 = 64'h00000008EFBEEFBE;
   localparam logic [127:0] TUSER_EXPECT = 128'hCAFEBEEFDEADCAFE;
   localparam logic [15:0] LFSR_SEED = 16'hACE1;
   localparam logic [15:0] LFSR_TAPS = 16'hD008;
   // Header bytes first, then payload word n carries n in every byte.
   function automatic logic [7:0] exp_byte(input logic [16:0] j, input logic [63:0] h0, input logic [63:0] h1);
      return j < 17'd8 ? h0[{j[2:0], 3'b000} +: 8] : j < 17'd16 ? h1[{j[2:0], 3'b000} +: 8] : 8'((j - 17'd16) >> 3);
   endfunction
endpackage

// File: rtl/nf10_axis_pkt_checker_if.sv
// nf10_axis_pkt_checker_if: AXI4-Stream bundle with master/slave views.
interface nf10_axis_pkt_checker_if #(
   parameter int DATA_WIDTH  = 64,
   parameter int TUSER_WIDTH = 128
);
   logic [DATA_WIDTH-1:0]   tdata;
   logic [DATA_WIDTH/8-1:0] tstrb;
   logic                    tvalid;
   logic                    tready;
   logic                    tlast;
   logic [TUSER_WIDTH-1:0]  tuser;
   modport master (output tdata, tstrb, tvalid, tlast, tuser, input tready);
   modport slave (input tdata, tstrb, tvalid, tlast, tuser, output tready);
endinterface

// File: rtl/nf10_lfsr16.sv
// nf10_lfsr16: free-running 16-bit Fibonacci LFSR (taps 16,15,13,4).
module nf10_lfsr16
   import nf10_axis_checker_pkg::*;
(
   input  logic clk,
   input  logic rst,
   output logic out
);
   logic [15:0] lfsr_q, lfsr_d;
   always_comb lfsr_d = {lfsr_q[14:0], ^(lfsr_q & LFSR_TAPS)};
   always_ff @(posedge clk or posedge rst) begin
      if (rst) lfsr_q <= LFSR_SEED;
      else lfsr_q <= lfsr_d;
   end
   assign out = lfsr_q[0];
endmodule

// File: rtl/nf10_axis_pkt_checker.sv
// nf10_axis_pkt_checker: AXIS sink that verifies test packets and counts good/bad ones.
// Define AXIS_CHECKER_BACKPRESSURE_EN to add LFSR-driven tready throttling.
module nf10_axis_pkt_checker
   import nf10_axis_checker_pkg::*;
#(
   parameter int C_S_AXIS_DATA_WIDTH = 64,
   parameter int C_S_AXIS_TUSER_WIDTH = 128,
   parameter logic [C_S_AXIS_TUSER_WIDTH-1:0] C_TUSER_EXPECT = C_S_AXIS_TUSER_WIDTH'(TUSER_EXPECT),
   parameter logic [63:0] C_HDR_WORD0 = HDR_WORD0,
   parameter logic [63:0] C_HDR_WORD1 = HDR_WORD1,
   parameter int C_PKT_BYTES = 128
) (
   input  logic                           axi_aclk,
   input  logic                           axi_reset,
   nf10_axis_pkt_checker_if.slave         s_axis,
   input  logic                           bp_enable,
   input  logic                           clear_stats,
   output logic [31:0]                    pkt_count,
   output logic [31:0]                    err_count,
   output logic                           err_flag,
   output logic [2:0]                     err_code
);
   localparam int NB = C_S_AXIS_DATA_WIDTH / 8;
   state_t      state_q, state_d;
   logic [15:0] off_q, off_d;
   logic [31:0] pkt_q, pkt_d, errc_q, errc_d;
   logic        flag_q, flag_d, rdy_en_q, tready_q, tready_d, gate;
   logic [2:0]  code_q, code_d, code;
   logic [16:0] n, nxt;
   logic        hs, strb_err, tuser_err, early, over, data_err, err_ev, done_ev;
`ifdef AXIS_CHECKER_BACKPRESSURE_EN
   logic lfsr_bit;
   nf10_lfsr16 u_lfsr (.clk(axi_aclk), .rst(axi_reset), .out(lfsr_bit));
   assign gate = bp_enable ? lfsr_bit : 1'b1;
`else
   logic unused_bp;
   assign unused_bp = bp_enable;
   assign gate = 1'b1;
`endif
   always_comb begin
      n = '0;
      data_err = 1'b0;
      for (int i = 0; i < NB; i++) n = n + 17'(s_axis.tstrb[i]);
      for (int i = 0; i < NB; i++)
         if (17'(i) < n && s_axis.tdata[8*i +: 8] != exp_byte(17'(off_q) + 17'(i), C_HDR_WORD0, C_HDR_WORD1))
            data_err = 1'b1;
      // Strobes must be a non-empty run of ones starting at lane 0.
      strb_err  = ~|s_axis.tstrb | |(s_axis.tstrb & (s_axis.tstrb + NB'(1)));
      tuser_err = state_q == IDLE && s_axis.tuser != C_TUSER_EXPECT;
      nxt       = 17'(off_q) + n;
      early     = s_axis.tlast && nxt < 17'(C_PKT_BYTES);
      over      = nxt > 17'(C_PKT_BYTES) || (nxt == 17'(C_PKT_BYTES) && !s_axis.tlast);
      code      = strb_err ? ERR_STRB : tuser_err ? ERR_TUSER : early ? ERR_EARLY :
                  over ? ERR_OVER : data_err ? ERR_DATA : ERR_NONE;
      hs        = s_axis.tvalid && tready_q;
      err_ev    = hs && state_q != DRAIN && code != ERR_NONE;
      done_ev   = hs && state_q != DRAIN && code == ERR_NONE && s_axis.tlast;
      state_d   = state_q;
      off_d     = off_q;
      if (hs) begin
         state_d = s_axis.tlast ? IDLE : (state_q == DRAIN || err_ev) ? DRAIN : PKT;
         off_d   = state_d == PKT ? nxt[15:0] : 16'd0;
      end
      pkt_d    = clear_stats ? '0 : pkt_q + 32'(done_ev);
      errc_d   = clear_stats ? '0 : errc_q + 32'(err_ev && !(&errc_q));
      flag_d   = clear_stats ? 1'b0 : flag_q | err_ev;
      code_d   = clear_stats ? ERR_NONE : err_ev ? code : code_q;
      tready_d = rdy_en_q & gate;
   end
   always_ff @(posedge axi_aclk or posedge axi_reset) begin
      if (axi_reset) begin
         state_q  <= IDLE;
         off_q    <= '0;
         pkt_q    <= '0;
         errc_q   <= '0;
         flag_q   <= 1'b0;
         code_q   <= ERR_NONE;
         rdy_en_q <= 1'b0;
         tready_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         off_q    <= off_d;
         pkt_q    <= pkt_d;
         errc_q   <= errc_d;
         flag_q   <= flag_d;
         code_q   <= code_d;
         rdy_en_q <= 1'b1;
         tready_q <= tready_d;
      end
   end
   assign s_axis.tready = tready_q;
   assign pkt_count     = pkt_q;
   assign err_count     = errc_q;
   assign err_flag      = flag_q;
   assign err_code      = code_q;
endmodule

// File: tb/tb_nf10_axis_pkt_checker.sv
// tb_nf10_axis_pkt_checker: directed self-checking bench for the 64-bit default build.
module tb_nf10_axis_pkt_checker;
   localparam logic [63:0]  H0 = 64'hEFBEFECAFECAFECA;
   localparam logic [63:0]  H1 = 64'h00000008EFBEEFBE;
   localparam logic [127:0] TU = 128'hCAFEBEEFDEADCAFE;
   logic clk = 1'b0, rst = 1'b1, bp_enable = 1'b0, clear_stats = 1'b0;
   logic [31:0] pkt_count, err_count;
   logic        err_flag;
   logic [2:0]  err_code;
   int checks = 0, fails = 0, cyc = 0, hs_cnt = 0, c0, h0;
   nf10_axis_pkt_checker_if #(.DATA_WIDTH(64), .TUSER_WIDTH(128)) bus ();
   nf10_axis_pkt_checker dut (
      .axi_aclk(clk), .axi_reset(rst), .s_axis(bus), .bp_enable(bp_enable),
      .clear_stats(clear_stats), .pkt_count(pkt_count), .err_count(err_count),
      .err_flag(err_flag), .err_code(err_code)
   );
   always #5 clk = ~clk;
   always @(negedge clk) begin
      cyc++;
      if (bus.tvalid && bus.tready) hs_cnt++;
   end
   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask
   task automatic beat(input logic [63:0] d, input logic [7:0] s, input logic l, input logic [127:0] u);
      int w;
      w = 0;
      bus.tvalid = 1'b1; bus.tdata = d; bus.tstrb = s; bus.tlast = l; bus.tuser = u;
      while (!bus.tready && w < 200) begin
         @(posedge clk); #1;
         w++;
      end
      if (w >= 200) chk("hs_timeout", 64'd0, 64'd1);
      @(posedge clk); #1;
   endtask
   task automatic send_pkt(input int nb, input int last_b, input int bad_b, input int strb_b,
                           input logic [7:0] strb_v, input logic [127:0] u, input bit clr_last);
      for (int b = 0; b < nb; b++) begin
         logic [63:0] d;
         d = b == 0 ? H0 : b == 1 ? H1 : {8{8'(b - 2)}};
         if (b == bad_b) d = {8{8'h06}};
         clear_stats = clr_last && b == last_b;
         beat(d, b == strb_b ? strb_v : 8'hFF, b == last_b, u);
      end
      clear_stats = 1'b0;
      bus.tvalid = 1'b0;
      bus.tlast = 1'b0;
   endtask
   task automatic good_pkt();
      send_pkt(16, 15, -1, -1, 8'hFF, TU, 1'b0);
   endtask
   task automatic clear();
      clear_stats = 1'b1;
      @(posedge clk); #1;
      clear_stats = 1'b0;
   endtask
   task automatic stats(input string tag, input int p, input int e, input logic f, input logic [2:0] c);
      chk({tag, "_pkt"}, 64'(pkt_count), 64'(p));
      chk({tag, "_err"}, 64'(err_count), 64'(e));
      chk({tag, "_flag"}, 64'(err_flag), 64'(f));
      chk({tag, "_code"}, 64'(err_code), 64'(c));
   endtask
   initial begin
      bus.tvalid = 1'b0; bus.tdata = '0; bus.tstrb = '0; bus.tlast = 1'b0; bus.tuser = '0;
      repeat (50) @(posedge clk);
      #1;
      chk("rst_tready", 64'(bus.tready), 64'd0);
      stats("rst", 0, 0, 1'b0, 3'd0);
      rst = 1'b0;
      @(posedge clk); #1;
      chk("tready_edge1", 64'(bus.tready), 64'd0);
      @(posedge clk); #1;
      chk("tready_edge2", 64'(bus.tready), 64'd1);
      c0 = cyc; h0 = hs_cnt;
      repeat (3) good_pkt();
      stats("good3", 3, 0, 1'b0, 3'd0);
      chk("good3_beats", 64'(hs_cnt - h0), 64'd48);
      chk("good3_cycles", 64'(cyc - c0), 64'd48);
      clear();
      stats("clr1", 0, 0, 1'b0, 3'd0);
      good_pkt();
      send_pkt(16, 15, 7, -1, 8'hFF, TU, 1'b0);
      stats("data_mid", 1, 1, 1'b1, 3'd5);
      good_pkt();
      stats("data", 2, 1, 1'b1, 3'd5);
      clear();
      send_pkt(10, 9, -1, -1, 8'hFF, TU, 1'b0);
      stats("early", 0, 1, 1'b1, 3'd3);
      good_pkt();
      chk("early_next_pkt", 64'(pkt_count), 64'd1);
      clear();
      send_pkt(18, 17, -1, -1, 8'hFF, TU, 1'b0);
      stats("over", 0, 1, 1'b1, 3'd4);
      good_pkt();
      stats("over_next", 1, 1, 1'b1, 3'd4);
      clear();
      send_pkt(16, 15, -1, 4, 8'h0F, 128'd0, 1'b0);
      stats("tuser", 0, 1, 1'b1, 3'd2);
      clear();
      stats("clr2", 0, 0, 1'b0, 3'd0);
      send_pkt(16, 15, -1, 3, 8'h05, TU, 1'b0);
      stats("strb", 0, 1, 1'b1, 3'd1);
      send_pkt(16, 15, -1, 0, 8'h05, 128'd0, 1'b0);
      stats("prio", 0, 2, 1'b1, 3'd1);
      clear();
      send_pkt(16, 15, -1, -1, 8'hFF, TU, 1'b1);
      chk("clr_wins_pkt", 64'(pkt_count), 64'd0);
      good_pkt();
      stats("after_clr", 1, 0, 1'b0, 3'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
      $finish;
   end
   initial begin
      #500000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end
endmodule
